mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port Memory between the CPU's instruction-fetch path and its data load/store path.
- Accepts one request per requester, grants one at a time, and sequences a fixed-latency memory access.
- Returns read data with a one-cycle acknowledge pulse.
- Sits between the PC/fetch logic, the load/store unit and the Memory instance; only one transaction is outstanding at a time.

Parameters:
- AW, 16, address width; matches pc width.
- DW, 16, data width; matches instruction/register width.
- MEM_LAT, 2, memory access cycles per transaction; legal range 1..15.
- STARVE_MAX, 3, consecutive data grants allowed while fetch waits; used only with the optional feature.

Ports:
- clk  in  1  clock.
- nRESET  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held high with if_addr stable until if_ack.
- if_addr  in  AW  fetch address.
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  DW  fetched instruction.
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_ack.
- d_we  in  1  0 = READ, 1 = WRITE.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle pulse; d_rdata valid in the same cycle.
- d_rdata  out  DW  load data; 0 for writes.
- mem_en  out  1  memory access active.
- mem_rw  out  1  0 = READ, 1 = WRITE.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid in the last ACCESS cycle.
- busy  out  1  high in ACCESS and DONE.
- grant_id  out  1  0 = fetch, 1 = data; meaningful while busy.

Behaviour:
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- Reset values: state IDLE; if_ack, d_ack, mem_en, mem_rw, busy, grant_id = 0; all addr/data outputs = 0; latency counter 0; starve counter 0.
- IDLE:
  - If any request is high, select a winner, latch its addr/we/wdata and grant_id, load counter with MEM_LAT-1, go to ACCESS.
  - Otherwise stay in IDLE.
- Priority: data wins over fetch when both are high, because the older instruction's access completes first.
- ACCESS:
  - mem_en = 1; mem_rw, mem_addr and mem_wdata are driven from the latched values.
  - Counter decrements each cycle.
  - In the cycle where counter = 0, capture mem_rdata, or 0 for writes, then go to DONE.
- DONE:
  - mem_en = 0; pulse the ack of the granted requester for exactly one cycle with registered rdata; the other ack stays 0.
  - Return to IDLE.
- Latency: request sampled at edge k gives ack high in cycle k+MEM_LAT+1. Minimum request-to-request spacing is MEM_LAT+2 cycles.
- Requests are not sampled in ACCESS or DONE. A req still high in IDLE after its ack is treated as a new transaction.
- The loser's request is held pending and is served on the next IDLE; it is never dropped.
- A write never produces rdata; d_rdata = 0 on a write ack.
- Reset mid-transaction: immediately return to IDLE, force acks/mem_en low, and discard the transaction. Requesters reissue after reset.
- Simultaneous requests arriving as state returns to IDLE are resolved by the priority rule; there is no lookahead grant in DONE.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- When defined:
  - A starve counter increments on each data grant made while if_req is high, and clears on any fetch grant.
  - When the counter equals STARVE_MAX and both requests are high, fetch wins that arbitration.
- When undefined:
  - Data priority is strict; the counter and STARVE_MAX logic are not generated.

Decomposition:
- Shared package cpu_pkg holds:
  - READ/WRITE constants (0/1).
  - State encoding IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - GNT_FETCH=1'b0 and GNT_DATA=1'b1.
- One natural sub-module: arb_priority_sel.
  - Combinational winner selection from if_req, d_req and the starve count.
  - Keeps the policy swappable; the FSM and datapath latches stay in the top module.

Test Plan:
- Fetch only, MEM_LAT=2, if_addr=16'h0004, mem_rdata=16'hA5C3 -> mem_en high for 2 cycles with mem_addr=0004 and mem_rw=0; if_ack pulses 3 cycles after the request is sampled; if_rdata=A5C3; d_ack stays 0.
- Data write, d_addr=16'h0100, d_wdata=16'h1234 -> mem_rw=1, mem_wdata=1234 for 2 cycles; d_ack pulse with d_rdata=0.
- Both requests in the same cycle -> data is granted first (grant_id=1); fetch is granted on the next IDLE; d_ack precedes if_ack by 4 cycles.
- Assert nRESET low in the second ACCESS cycle -> next observation shows busy=0, mem_en=0, no ack; after release, a held if_req is re-served with full latency.
- With ARB_STARVE_GUARD_EN, STARVE_MAX=3, both requests held high continuously -> grant sequence D,D,D,F,D,D,D,F. Without the macro -> all D until d_req drops.
- MEM_LAT=1 back-to-back fetches at addresses 0, 2, 4 -> acks spaced 3 cycles apart with the correct rdata for each.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: transfer direction, arbiter state encoding and
// grant identifiers used by the memory port arbiter.
package cpu_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  // Wide enough for MEM_LAT-1 (MEM_LAT <= 15) and for the starve count.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_priority_sel.sv
// Winner selection between fetch and data requests. Data normally wins;
// with ARB_STARVE_GUARD_EN defined, a waiting fetch wins once starve_cnt hits STARVE_MAX.
module arb_priority_sel
  import cpu_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
  parameter int STARVE_MAX = 3
)
`endif
(
  input  logic             if_req,
  input  logic             d_req,
`ifdef ARB_STARVE_GUARD_EN
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  output logic             req_any,
  output logic             grant_sel
);

  // Combinational arbitration policy
  always_comb begin
    req_any   = if_req | d_req;
    grant_sel = GNT_FETCH;
`ifdef ARB_STARVE_GUARD_EN
    if (if_req && d_req && (starve_cnt == CNT_W'(STARVE_MAX))) begin
      grant_sel = GNT_FETCH;
    end else if (d_req) begin
      grant_sel = GNT_DATA;
    end else begin
      grant_sel = GNT_FETCH;
    end
`else
    if (d_req) begin
      grant_sel = GNT_DATA;
    end else begin
      grant_sel = GNT_FETCH;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one fixed-latency transaction at a time. Optional macro: ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = 3
`endif
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             if_ack_q, if_ack_d;
  logic             d_ack_q, d_ack_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_rw_q, mem_rw_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic             grant_id_q, grant_id_d;
  logic             req_any_s;
  logic             grant_sel_s;
`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_q, starve_d;
`endif

  arb_priority_sel
`ifdef ARB_STARVE_GUARD_EN
    #(.STARVE_MAX(STARVE_MAX))
`endif
    u_sel (
    .if_req    (if_req),
    .d_req     (d_req),
`ifdef ARB_STARVE_GUARD_EN
    .starve_cnt(starve_q),
`endif
    .req_any   (req_any_s),
    .grant_sel (grant_sel_s)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    mem_en_d    = mem_en_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    grant_id_d  = grant_id_q;
`ifdef ARB_STARVE_GUARD_EN
    starve_d    = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_any_s) begin
          grant_id_d = grant_sel_s;
          if (grant_sel_s == GNT_DATA) begin
            mem_rw_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_rw_d    = READ;
            mem_addr_d  = if_addr;
            mem_wdata_d = {DW{1'b0}};
          end
`ifdef ARB_STARVE_GUARD_EN
          // Count data grants that made a fetch wait; a fetch grant clears it.
          if (grant_sel_s == GNT_FETCH) begin
            starve_d = {CNT_W{1'b0}};
          end else if (if_req) begin
            starve_d = starve_q + CNT_W'(1);
          end else begin
            starve_d = starve_q;
          end
`endif
          mem_en_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = LAT_LOAD;
          state_d  = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          rdata_d  = (mem_rw_q == WRITE) ? {DW{1'b0}} : mem_rdata;
          mem_en_d = 1'b0;
          if_ack_d = (grant_id_q == GNT_FETCH);
          d_ack_d  = (grant_id_q == GNT_DATA);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        mem_en_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // FSM and output registers; reset discards any in-flight transaction
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      rdata_q     <= {DW{1'b0}};
      busy_q      <= 1'b0;
      grant_id_q  <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q    <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      grant_id_q  <= grant_id_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_q    <= starve_d;
`endif
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// grants, memory contents and ack timing; a negedge monitor compares.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MEM_LAT = 2;
`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_MAX = 3;
`endif

  logic          clk = 1'b0;
  logic          nRESET;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_ack, d_ack, mem_en, mem_rw, busy, grant_id;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)
`ifdef ARB_STARVE_GUARD_EN
    , .STARVE_MAX(STARVE_MAX)
`endif
  ) dut (
    .clk(clk), .nRESET(nRESET),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    logic [15:0] v;
    v = 16'(i) * 16'h0101 ^ 16'h3C96;
    if (i == 4) v = 16'hA5C3;
    return v;
  endfunction

  // Memory instance stand-in: combinational read, write on clock edge
  logic [15:0] mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_en && mem_rw) mem[mem_addr[7:0]] = mem_wdata;
    end
  end

  // Reference model: one transaction at a time, next arbitration MEM_LAT+2 edges later
  typedef struct {
    logic        is_data;
    logic [15:0] rdata;
    int          ack_edge;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_e, mon_e;
  logic [15:0] ref_mem [256];
  int          cyc = 0;
  int          next_free = 0;
  logic        m_data;
  logic        cur_v = 1'b0;
  int          cur_g = 0;
  logic        cur_data, cur_we;
  logic [15:0] cur_addr, cur_wdata;
`ifdef ARB_STARVE_GUARD_EN
  int          streak = 0;
`endif

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      cyc++;
      if (nRESET !== 1'b1) begin
        exp_q.delete();
        cur_v = 1'b0;
        next_free = cyc + 1;
`ifdef ARB_STARVE_GUARD_EN
        streak = 0;
`endif
      end else if (cyc >= next_free && (if_req || d_req)) begin
        m_data = d_req;
`ifdef ARB_STARVE_GUARD_EN
        if (if_req && d_req && streak == STARVE_MAX) m_data = 1'b0;
        if (!m_data) streak = 0;
        else if (if_req) streak++;
`endif
        cur_v     = 1'b1;
        cur_g     = cyc;
        cur_data  = m_data;
        cur_we    = m_data ? d_we : 1'b0;
        cur_addr  = m_data ? d_addr : if_addr;
        cur_wdata = d_wdata;
        m_e.is_data  = m_data;
        m_e.ack_edge = cyc + MEM_LAT;
        if (cur_we) begin
          m_e.rdata = 16'h0000;
          ref_mem[cur_addr[7:0]] = cur_wdata;
        end else begin
          m_e.rdata = ref_mem[cur_addr[7:0]];
        end
        exp_q.push_back(m_e);
        next_free = cyc + MEM_LAT + 2;
      end
    end
  end

  // Monitor: compares bus activity and acks against the model every cycle
  initial begin
    logic exp_en, exp_busy;
    forever begin
      @(negedge clk);
      if (nRESET === 1'b1) begin
        exp_en   = cur_v && cyc >= cur_g && cyc < cur_g + MEM_LAT;
        exp_busy = cur_v && cyc >= cur_g && cyc <= cur_g + MEM_LAT;
        chk("mem_en", mem_en, exp_en);
        chk("busy", busy, exp_busy);
        if (exp_busy) chk("grant_id", grant_id, cur_data);
        if (exp_en) begin
          chk("mem_addr", mem_addr, cur_addr);
          chk("mem_rw", mem_rw, cur_we);
          if (cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
        end
        chk("ack_onehot", if_ack & d_ack, 1'b0);
        if (if_ack || d_ack) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_unexpected: actual if_ack=%b d_ack=%b required none", if_ack, d_ack);
          end else begin
            mon_e = exp_q.pop_front();
            chk("ack_who", d_ack, mon_e.is_data);
            chk("ack_cycle", cyc, mon_e.ack_edge);
            chk("rdata", mon_e.is_data ? d_rdata : if_rdata, mon_e.rdata);
          end
        end else if (exp_q.size() > 0 && exp_q[0].ack_edge <= cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL ack_missing: actual none required ack at edge %0d", exp_q[0].ack_edge);
          mon_e = exp_q.pop_front();
        end
      end
    end
  end

  // Waits for an ack (mode 0 fetch, 1 data, 2 either) with a cycle budget
  task automatic wait_ack(input int mode, output int n, output logic who);
    logic hit;
    n = 0;
    hit = 1'b0;
    who = 1'b0;
    while (!hit && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      hit = (mode == 0) ? if_ack : (mode == 1) ? d_ack : (if_ack | d_ack);
      who = d_ack;
    end
    if (!hit) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: actual no ack after %0d cycles required ack (mode %0d)", n, mode);
    end
  endtask

  task automatic rand_step(input int p_if, input int p_d);
    if (if_req) begin
      if (if_ack) begin
        if_req  = ($urandom_range(99) < p_if);
        if_addr = 16'($urandom);
      end
    end else if ($urandom_range(99) < p_if) begin
      if_req  = 1'b1;
      if_addr = 16'($urandom);
    end
    if (d_req) begin
      if (d_ack) begin
        d_req   = ($urandom_range(99) < p_d);
        d_we    = 1'($urandom);
        d_addr  = 16'($urandom);
        d_wdata = 16'($urandom);
      end
    end else if ($urandom_range(99) < p_d) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom);
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
    end
  endtask

  initial begin
    int   n, n2;
    logic who, exp_who;
    nRESET = 1'b0;
    if_req = 1'b0; if_addr = 16'h0000;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_if_ack", if_ack, 1'b0);
    chk("rst_d_ack", d_ack, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_rw", mem_rw, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_if_rdata", if_rdata, 16'h0000);
    chk("rst_d_rdata", d_rdata, 16'h0000);
    @(posedge clk); #1; nRESET = 1'b1;

    // Fetch only
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0004;
    wait_ack(0, n, who);
    chk("fetch_latency", n, MEM_LAT + 1);
    chk("fetch_rdata", if_rdata, 16'hA5C3);
    chk("fetch_no_dack", d_ack, 1'b0);
    if_req = 1'b0;

    // Data write then read-back
    repeat (2) @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
    wait_ack(1, n, who);
    chk("write_latency", n, MEM_LAT + 1);
    chk("write_rdata_zero", d_rdata, 16'h0000);
    d_we = 1'b0;
    wait_ack(1, n, who);
    chk("readback", d_rdata, 16'h1234);
    d_req = 1'b0;

    // Simultaneous requests: data first, fetch on the following IDLE
    repeat (2) @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    wait_ack(1, n, who);
    chk("both_data_first", if_ack, 1'b0);
    d_req = 1'b0;
    wait_ack(0, n2, who);
    chk("both_ack_spacing", n2, MEM_LAT + 2);
    if_req = 1'b0;

    // Reset during the second ACCESS cycle, held fetch re-served afterwards
    repeat (2) @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0006;
    repeat (2) @(posedge clk);
    #1;
    nRESET = 1'b0;
    #3;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mem_en", mem_en, 1'b0);
    chk("midrst_acks", {if_ack, d_ack}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    nRESET = 1'b1;
    wait_ack(0, n, who);
    chk("rst_reserve_latency", n, MEM_LAT + 1);
    chk("rst_reserve_rdata", if_rdata, init_val(6));
    if_req = 1'b0;

    // Both held continuously: grant order
    repeat (2) @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0030;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    for (int i = 0; i < 8; i++) begin
      wait_ack(2, n, who);
`ifdef ARB_STARVE_GUARD_EN
      exp_who = (i % 4 == 3) ? 1'b0 : 1'b1;
`else
      exp_who = 1'b1;
`endif
      chk("held_grant_seq", who, exp_who);
    end
    if_req = 1'b0; d_req = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      case ((i / 500) % 3)
        0: rand_step(30, 30);
        1: rand_step(90, 90);
        default: rand_step(70, 15);
      endcase
    end
    for (int i = 0; i < 200 && (if_req || d_req); i++) begin
      @(posedge clk); #1;
      rand_step(0, 0);
    end
    repeat (6) @(posedge clk);
    #1;
    chk("drained_reqs", {if_req, d_req}, 2'b00);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
